ota_sd_decimator: RTL and testbench

- Downstream consumer of the digital OTA comparator output (1-bit Out) in a first-order sigma-delta loop.
- Synchronises the asynchronous comparator bit and re-registers it as the feedback/DAC bit returned to the loop.
- Decimates the bitstream with a sinc1 (count-the-ones) filter over a fixed OSR window.
- Presents each N-bit sample with a sticky valid flag, read strobe and overrun flag for the host or output mux.

---
 rtl/ota_sd_decimator.sv | 81 ++++++++
 tb/tb_ota_sd_decimator.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ota_sd_decimator.sv
// rtl/ota_sd_decimator.sv - comparator sync, loop feedback register and sinc1 decimator
module ota_sd_decimator #(
    parameter int OSR_LOG2 = 8,
    parameter int OUT_W    = OSR_LOG2 + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cmp_in,
    input  logic             rd,
    input  logic             clr_ovr,
    output logic             fb_out,
    output logic [OUT_W-1:0] sample,
    output logic             sample_valid,
    output logic             overrun,
    output logic             frame_tick
);
    localparam logic [OSR_LOG2-1:0] WCNT_LAST = {OSR_LOG2{1'b1}};

    logic                s1;
    logic                s2;
    logic [OSR_LOG2-1:0] wcnt;
    logic [OUT_W-1:0]    acc;
    logic [OUT_W-1:0]    acc_next;
    logic                done;

    assign acc_next = acc + OUT_W'(s2);
    assign done     = en && (wcnt == WCNT_LAST);

    // Sync chain keeps running while disabled so the loop sees a settled bit on re-enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= cmp_in;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fb_out <= 1'b0;
            acc    <= '0;
            wcnt   <= '0;
            sample <= '0;
        end else if (en) begin
            fb_out <= s2;
            if (done) begin
                sample <= acc_next;
                acc    <= '0;
                wcnt   <= '0;
            end else begin
                acc    <= acc_next;
                wcnt   <= wcnt + OSR_LOG2'(1);
            end
        end
    end

    // A completing window beats a simultaneous read; a new overrun beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            frame_tick   <= 1'b0;
        end else begin
            frame_tick <= done;
            if (done) begin
                sample_valid <= 1'b1;
            end else if (rd) begin
                sample_valid <= 1'b0;
            end
            if (done && sample_valid && !rd) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ota_sd_decimator.sv
// tb/tb_ota_sd_decimator.sv - scoreboard bench for ota_sd_decimator at OSR=16
module tb_ota_sd_decimator;
    localparam int OSR_LOG2 = 4;
    localparam int OUT_W    = 5;
    localparam int OSR      = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             cmp_in = 1'b0;
    logic             rd = 1'b0;
    logic             clr_ovr = 1'b0;
    logic             fb_out;
    logic [OUT_W-1:0] sample;
    logic             sample_valid;
    logic             overrun;
    logic             frame_tick;

    ota_sd_decimator #(.OSR_LOG2(OSR_LOG2), .OUT_W(OUT_W)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .cmp_in(cmp_in),
        .rd(rd),
        .clr_ovr(clr_ovr),
        .fb_out(fb_out),
        .sample(sample),
        .sample_valid(sample_valid),
        .overrun(overrun),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];

    logic m1, m2, mfb, mvalid, movr, mtick;
    int   macc, mwcnt, edge_n, gate_n;
    logic gate_got;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    task automatic model_reset();
        m1 = 1'b0; m2 = 1'b0; mfb = 1'b0; mvalid = 1'b0; movr = 1'b0; mtick = 1'b0;
        macc = 0; mwcnt = 0; edge_n = 0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_fb_out", 32'(fb_out), 0);
        check("rst_sample", 32'(sample), 0);
        check("rst_sample_valid", 32'(sample_valid), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_frame_tick", 32'(frame_tick), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic step(input logic c, input logic e, input logic r, input logic co);
        cmp_in = c; en = e; rd = r; clr_ovr = co;
        @(posedge clk);
        edge_n++;
        mtick = 1'b0;
        if (e) begin
            mfb = m2;
            if (mwcnt == OSR - 1) begin
                exp_q.push_back(macc + 32'(m2));
                macc  = 0;
                mwcnt = 0;
                mtick = 1'b1;
            end else begin
                macc  = macc + 32'(m2);
                mwcnt = mwcnt + 1;
            end
        end
        if (mtick && mvalid && !r) movr = 1'b1;
        else if (co) movr = 1'b0;
        if (mtick) mvalid = 1'b1;
        else if (r) mvalid = 1'b0;
        m2 = m1;
        m1 = c;
        #1;
        check("frame_tick", 32'(frame_tick), 32'(mtick));
        if (frame_tick) begin
            if (exp_q.size() == 0) check("sample_unexpected", 32'(sample), -1);
            else check("sample", 32'(sample), exp_q.pop_front());
        end
        check("fb_out", 32'(fb_out), 32'(mfb));
        check("sample_valid", 32'(sample_valid), 32'(mvalid));
        check("overrun", 32'(overrun), 32'(movr));
        rd = 1'b0;
        clr_ovr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        do_reset();

        // steady ones from reset
        for (int i = 1; i <= 32; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            if (i == 2) check("ones_fb_edge2", 32'(fb_out), 0);
            if (i == 3) check("ones_fb_edge3", 32'(fb_out), 1);
            if (i == 16) begin
                check("ones_tick_edge16", 32'(frame_tick), 1);
                check("ones_first_sample", 32'(sample), 14);
            end
            if (i == 32) check("ones_second_sample", 32'(sample), 16);
        end

        // alternating bitstream with periodic reads
        for (int i = 0; i < 48; i++) begin
            if (i == 20) check("alt_valid_before_rd", 32'(sample_valid), 1);
            step(i[0], 1'b1, (i % 16) == 4, i == 0);
            if (i == 20) check("alt_valid_after_rd", 32'(sample_valid), 0);
        end
        check("alt_sample", 32'(sample), 8);

        // zeros, overrun, clear, read on completion, set beats clear
        do_reset();
        for (int i = 1; i <= 32; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            if (i == 16) begin
                check("zero_sample", 32'(sample), 0);
                check("zero_valid", 32'(sample_valid), 1);
                check("zero_no_overrun", 32'(overrun), 0);
            end
            if (i == 32) check("ovr_set", 32'(overrun), 1);
        end
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("ovr_cleared", 32'(overrun), 0);
        for (int i = 34; i <= 47; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("rd_on_done_valid", 32'(sample_valid), 1);
        check("rd_on_done_ovr", 32'(overrun), 0);
        for (int i = 49; i <= 63; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("ovr_set_beats_clr", 32'(overrun), 1);

        // single one-edge pulse within a window
        for (int i = 65; i <= 80; i++) begin
            step(i == 70, 1'b1, 1'b0, 1'b0);
            if (i == 71) check("pulse_fb_edge71", 32'(fb_out), 0);
            if (i == 72) check("pulse_fb_edge72", 32'(fb_out), 1);
            if (i == 73) check("pulse_fb_edge73", 32'(fb_out), 0);
            if (i == 80) check("pulse_sample", 32'(sample), 1);
        end

        // enable gating mid-window
        do_reset();
        for (int i = 1; i <= 20; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            check("gate_fb_frozen", 32'(fb_out), 1);
            check("gate_no_tick", 32'(frame_tick), 0);
        end
        gate_n = 0;
        gate_got = 1'b0;
        while (!gate_got && gate_n < 30) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            gate_n++;
            if (frame_tick) gate_got = 1'b1;
        end
        check("gate_tick_edge", edge_n, 37);
        check("gate_sample", 32'(sample), 16);

        // reset in the middle of a window
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        do_reset();
        for (int i = 1; i <= 16; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        check("midrst_tick", 32'(frame_tick), 1);
        check("midrst_sample", 32'(sample), 14);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
